traffic_light_ctrl_nway: RTL and testbench

Parametrised N-approach signalised-intersection controller. It is the successor to the fixed 4-way, fixed-order controller.
- Adds configurable direction count and an all-red clearance interval.
- Adds demand-actuated phase skipping, emergency preemption and a flashing-red fail-safe mode.
- Sits between the detector/pre-emption input logic and the lamp drivers, one 3-bit lamp field per approach.

---
 rtl/traffic_pkg.sv | 24 ++
 rtl/rr_next_dir.sv | 35 +++
 rtl/traffic_light_ctrl_nway.sv | 163 ++++++++++++++++
 tb/tb_traffic_light_ctrl_nway.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the N-approach traffic light controller family.
//   phase_t   : controller phase, also exported on the top-level phase output
//   LAMP_*    : 3-bit lamp field encodings (one field per approach)
//   dir_w()   : width of an approach index for a given approach count
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2,
        FLASH  = 2'd3
    } phase_t;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_DARK   = 3'b000;

    // At least one bit, even for a two-approach intersection.
    function automatic int dir_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_next_dir.sv
// Combinational round-robin scan: picks the first approach after cur_dir
// (wrapping modulo NUM_DIR, cur_dir itself excluded) whose demand bit is set.
// With no other approach requesting, the result is simply cur_dir+1.
//   demand   : per-approach request bits
//   cur_dir  : approach currently being served
//   next_dir : approach to serve next
module rr_next_dir
    import traffic_pkg::*;
#(
    parameter int  NUM_DIR = 4,
    localparam int DIR_W   = dir_w(NUM_DIR)
) (
    input  logic [NUM_DIR-1:0] demand,
    input  logic [DIR_W-1:0]   cur_dir,
    output logic [DIR_W-1:0]   next_dir
);

    logic             found;
    logic [DIR_W-1:0] idx;

    always_comb begin
        next_dir = DIR_W'((int'(cur_dir) + 1) % NUM_DIR);
        found    = 1'b0;
        idx      = '0;
        // Nearest-first scan; the first hit wins.
        for (int k = 1; k < NUM_DIR; k++) begin
            idx = DIR_W'((int'(cur_dir) + k) % NUM_DIR);
            if (!found && demand[idx]) begin
                next_dir = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_light_ctrl_nway.sv
// N-approach signalised intersection controller.
// Sequence GREEN(d) -> YELLOW(d) -> ALLRED -> GREEN(next), with demand-based
// skipping, emergency preemption (holds green on the requested approach) and
// a flashing-red fail-safe mode that has priority over preemption.
//   clk, rst       : clock, synchronous active-high reset
//   demand         : per-approach request (level)
//   preempt_req    : emergency preemption request (level)
//   preempt_dir    : approach to serve during preemption
//   flash_mode     : fail-safe flashing-red request (level)
//   lights         : 3-bit lamp field per approach, approach d at [3d+2:3d]
//   active_dir     : approach owning green/yellow
//   phase          : current phase_t (also serves as the FSM state view)
//   preempt_active : high while a preemption green is being served
module traffic_light_ctrl_nway
    import traffic_pkg::*;
#(
    parameter int  NUM_DIR    = 4,
    parameter int  GREEN_CYC  = 70,
    parameter int  YELLOW_CYC = 20,
    parameter int  ALLRED_CYC = 5,
    parameter int  FLASH_CYC  = 10,
    parameter int  CNT_W      = 16,
    localparam int DIR_W      = dir_w(NUM_DIR)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_DIR-1:0]   demand,
    input  logic                 preempt_req,
    input  logic [DIR_W-1:0]     preempt_dir,
    input  logic                 flash_mode,
    output logic [3*NUM_DIR-1:0] lights,
    output logic [DIR_W-1:0]     active_dir,
    output logic [1:0]           phase,
    output logic                 preempt_active
);

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    // One extra bit so NUM_DIR itself is representable (e.g. 4 with DIR_W=2).
    localparam logic [DIR_W:0]   NUM_DIR_L   = (DIR_W + 1)'(NUM_DIR);

    phase_t             phase_q;
    logic [DIR_W-1:0]   active_dir_q;
    logic [DIR_W-1:0]   next_sel_q;
    logic [CNT_W-1:0]   count_q;
    logic               blink_q;
    logic               preempt_active_q;

    logic [DIR_W-1:0]   next_dir_d;
    logic               pre_valid;
    logic               pre_match;

    // An out-of-range preempt_dir (possible when NUM_DIR is not a power of
    // two) makes the whole request void.
    assign pre_valid = preempt_req && ({1'b0, preempt_dir} < NUM_DIR_L);
    assign pre_match = (preempt_dir == active_dir_q);

    rr_next_dir #(
        .NUM_DIR (NUM_DIR)
    ) u_rr_next_dir (
        .demand   (demand),
        .cur_dir  (active_dir_q),
        .next_dir (next_dir_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q          <= GREEN;
            active_dir_q     <= '0;
            next_sel_q       <= '0;
            count_q          <= '0;
            blink_q          <= 1'b0;
            preempt_active_q <= 1'b0;
        end else begin
            preempt_active_q <= 1'b0;
            case (phase_q)
                GREEN: begin
                    if (flash_mode || (pre_valid && !pre_match)) begin
                        // Truncate green: flash request or another approach
                        // is being preempted.
                        phase_q <= YELLOW;
                        count_q <= '0;
                    end else if (pre_valid) begin
                        // Serving the preempted approach: timer frozen.
                        preempt_active_q <= 1'b1;
                    end else if (count_q == GREEN_LAST) begin
                        phase_q <= YELLOW;
                        count_q <= '0;
                    end else begin
                        count_q <= count_q + CNT_ONE;
                    end
                end
                YELLOW: begin
                    if (count_q == YELLOW_LAST) begin
                        phase_q    <= ALLRED;
                        count_q    <= '0;
                        // Demand is sampled on the last yellow cycle only.
                        next_sel_q <= next_dir_d;
                    end else begin
                        count_q <= count_q + CNT_ONE;
                    end
                end
                ALLRED: begin
                    if (count_q == ALLRED_LAST) begin
                        count_q <= '0;
                        if (flash_mode) begin
                            phase_q <= FLASH;
                            blink_q <= 1'b1;
                        end else if (pre_valid) begin
                            phase_q          <= GREEN;
                            active_dir_q     <= preempt_dir;
                            preempt_active_q <= 1'b1;
                        end else begin
                            phase_q      <= GREEN;
                            active_dir_q <= next_sel_q;
                        end
                    end else begin
                        count_q <= count_q + CNT_ONE;
                    end
                end
                FLASH: begin
                    if (!flash_mode) begin
                        // Leave through a clearance interval, restart at approach 0.
                        phase_q    <= ALLRED;
                        count_q    <= '0;
                        blink_q    <= 1'b0;
                        next_sel_q <= '0;
                    end else if (count_q == FLASH_LAST) begin
                        count_q <= '0;
                        blink_q <= ~blink_q;
                    end else begin
                        count_q <= count_q + CNT_ONE;
                    end
                end
                default: begin
                    phase_q <= ALLRED;
                    count_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        lights = '0;
        for (int d = 0; d < NUM_DIR; d++) begin
            case (phase_q)
                GREEN:   lights[3*d +: 3] = (DIR_W'(d) == active_dir_q) ? LAMP_GREEN : LAMP_RED;
                YELLOW:  lights[3*d +: 3] = (DIR_W'(d) == active_dir_q) ? LAMP_YELLOW : LAMP_RED;
                ALLRED:  lights[3*d +: 3] = LAMP_RED;
                FLASH:   lights[3*d +: 3] = blink_q ? LAMP_RED : LAMP_DARK;
                default: lights[3*d +: 3] = LAMP_RED;
            endcase
        end
    end

    assign active_dir     = active_dir_q;
    assign phase          = phase_q;
    assign preempt_active = preempt_active_q;

endmodule

// File: tb/tb_traffic_light_ctrl_nway.sv
// Bench for traffic_light_ctrl_nway: a 4-approach build for the main scenarios
// and a 5-approach build for the out-of-range preemption case.
module tb_traffic_light_ctrl_nway;

    localparam int PH_G = 0;
    localparam int PH_Y = 1;
    localparam int PH_A = 2;
    localparam int PH_F = 3;

    typedef struct {
        int cyc;
        int ph;
        int dir;
        int pa;
    } vec_t;

    vec_t tbl[$];

    logic        clk;
    // 4-approach instance
    logic        rst4;
    logic [3:0]  demand4;
    logic        preq4;
    logic [1:0]  pdir4;
    logic        flash4;
    logic [11:0] lights4;
    logic [1:0]  adir4;
    logic [1:0]  phase4;
    logic        pa4;
    // 5-approach instance
    logic        rst5;
    logic [4:0]  demand5;
    logic        preq5;
    logic [2:0]  pdir5;
    logic        flash5;
    logic [14:0] lights5;
    logic [2:0]  adir5;
    logic [1:0]  phase5;
    logic        pa5;

    int n_checks;
    int n_errors;
    int cyc;

    traffic_light_ctrl_nway #(
        .NUM_DIR(4), .GREEN_CYC(7), .YELLOW_CYC(2), .ALLRED_CYC(1), .FLASH_CYC(3), .CNT_W(16)
    ) dut4 (
        .clk(clk), .rst(rst4), .demand(demand4), .preempt_req(preq4), .preempt_dir(pdir4),
        .flash_mode(flash4), .lights(lights4), .active_dir(adir4), .phase(phase4),
        .preempt_active(pa4)
    );

    traffic_light_ctrl_nway #(
        .NUM_DIR(5), .GREEN_CYC(7), .YELLOW_CYC(2), .ALLRED_CYC(1), .FLASH_CYC(3), .CNT_W(16)
    ) dut5 (
        .clk(clk), .rst(rst5), .demand(demand5), .preempt_req(preq5), .preempt_dir(pdir5),
        .flash_mode(flash5), .lights(lights5), .active_dir(adir5), .phase(phase5),
        .preempt_active(pa5)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- model ----------------
    function automatic logic [31:0] exp_lights(input int n, input int ph, input int dir, input bit blink);
        logic [31:0] r;
        r = '0;
        for (int d = 0; d < n; d++) begin
            case (ph)
                PH_G:    r[3*d +: 3] = (d == dir) ? 3'b001 : 3'b100;
                PH_Y:    r[3*d +: 3] = (d == dir) ? 3'b010 : 3'b100;
                PH_A:    r[3*d +: 3] = 3'b100;
                default: r[3*d +: 3] = blink ? 3'b100 : 3'b000;
            endcase
        end
        return r;
    endfunction

    function automatic vec_t mk(input int c, input int ph, input int dir, input int pa);
        vec_t v;
        v.cyc = c;
        v.ph  = ph;
        v.dir = dir;
        v.pa  = pa;
        return v;
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic check4(input string name, input int ph, input int dir, input int pa);
        check({name, "_phase"},  32'(phase4),  32'(ph));
        check({name, "_dir"},    32'(adir4),   32'(dir));
        check({name, "_pa"},     32'(pa4),     32'(pa));
        check({name, "_lights"}, 32'(lights4), exp_lights(4, ph, dir, 1'b0));
    endtask

    task automatic check5(input string name, input int ph, input int dir, input int pa);
        check({name, "_phase"},  32'(phase5),  32'(ph));
        check({name, "_dir"},    32'(adir5),   32'(dir));
        check({name, "_pa"},     32'(pa5),     32'(pa));
        check({name, "_lights"}, 32'(lights5), exp_lights(5, ph, dir, 1'b0));
    endtask

    task automatic check_flash(input string name, input logic [11:0] exp_l);
        check({name, "_phase"},  32'(phase4),  32'(PH_F));
        check({name, "_lights"}, 32'(lights4), 32'(exp_l));
    endtask

    task automatic reset4();
        rst4 = 1'b1;
        step(2);
        rst4 = 1'b0;
        cyc = 0;
    endtask

    task automatic reset5();
        rst5 = 1'b1;
        step(2);
        rst5 = 1'b0;
        cyc = 0;
    endtask

    // Walks cycles 0..last and checks every table entry on its cycle.
    task automatic run_table(input string name, input bit use5, input int last);
        for (int c = 0; c <= last; c++) begin
            foreach (tbl[i]) begin
                if (tbl[i].cyc == c) begin
                    if (use5) check5(name, tbl[i].ph, tbl[i].dir, tbl[i].pa);
                    else      check4(name, tbl[i].ph, tbl[i].dir, tbl[i].pa);
                end
            end
            if (c < last) tick();
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst4 = 1'b1; demand4 = '0; preq4 = 1'b0; pdir4 = '0; flash4 = 1'b0;
        rst5 = 1'b1; demand5 = '0; preq5 = 1'b0; pdir5 = '0; flash5 = 1'b0;

        // 1. Round-robin with all approaches requesting
        reset4();
        demand4 = 4'b1111;
        tbl.delete();
        tbl.push_back(mk(0,  PH_G, 0, 0));
        tbl.push_back(mk(6,  PH_G, 0, 0));
        tbl.push_back(mk(7,  PH_Y, 0, 0));
        tbl.push_back(mk(8,  PH_Y, 0, 0));
        tbl.push_back(mk(9,  PH_A, 0, 0));
        tbl.push_back(mk(10, PH_G, 1, 0));
        tbl.push_back(mk(17, PH_Y, 1, 0));
        tbl.push_back(mk(19, PH_A, 1, 0));
        tbl.push_back(mk(20, PH_G, 2, 0));
        tbl.push_back(mk(30, PH_G, 3, 0));
        tbl.push_back(mk(39, PH_A, 3, 0));
        tbl.push_back(mk(40, PH_G, 0, 0));
        run_table("rr", 1'b0, 40);

        // 2. Demand-based skipping
        reset4();
        demand4 = 4'b0101;
        tbl.delete();
        tbl.push_back(mk(7,  PH_Y, 0, 0));
        tbl.push_back(mk(9,  PH_A, 0, 0));
        tbl.push_back(mk(10, PH_G, 2, 0));
        tbl.push_back(mk(17, PH_Y, 2, 0));
        tbl.push_back(mk(19, PH_A, 2, 0));
        tbl.push_back(mk(20, PH_G, 0, 0));
        run_table("skip", 1'b0, 20);

        // 3. Preemption of approach 3 during approach 0 green
        reset4();
        demand4 = 4'b1111;
        step(3);
        check4("pre_c3", PH_G, 0, 0);
        preq4 = 1'b1;
        pdir4 = 2'd3;
        step(1);
        check4("pre_c4", PH_Y, 0, 0);
        step(2);
        check4("pre_c6", PH_A, 0, 0);
        step(1);
        check4("pre_c7", PH_G, 3, 1);
        for (int i = 0; i < 49; i++) begin
            step(1);
            check4("pre_hold", PH_G, 3, 1);
        end
        preq4 = 1'b0;
        step(1);
        check4("pre_rel57", PH_G, 3, 0);
        step(5);
        check4("pre_rel62", PH_G, 3, 0);
        step(1);
        check4("pre_rel63", PH_Y, 3, 0);
        step(2);
        check4("pre_rel65", PH_A, 3, 0);
        step(1);
        check4("pre_rel66", PH_G, 0, 0);

        // 4. Flashing-red fail-safe entered mid-green
        reset4();
        demand4 = 4'b1111;
        step(3);
        flash4 = 1'b1;
        step(1);
        check4("fl_c4", PH_Y, 0, 0);
        step(2);
        check4("fl_c6", PH_A, 0, 0);
        step(1);
        check_flash("fl_c7", 12'h924);
        step(2);
        check_flash("fl_c9", 12'h924);
        step(1);
        check_flash("fl_c10", 12'h000);
        step(2);
        check_flash("fl_c12", 12'h000);
        step(1);
        check_flash("fl_c13", 12'h924);
        step(3);
        check_flash("fl_c16", 12'h000);
        step(1);
        check_flash("fl_c17", 12'h000);
        flash4 = 1'b0;
        step(1);
        check("fl_c18_phase",  32'(phase4),  32'(PH_A));
        check("fl_c18_lights", 32'(lights4), 32'h924);
        step(1);
        check4("fl_c19", PH_G, 0, 0);

        // 5. Reset during approach 2 yellow
        reset4();
        demand4 = 4'b1111;
        step(27);
        check("rst_c27_lights", 32'(lights4), 32'h8A4);
        rst4 = 1'b1;
        step(1);
        check("rst_now_lights", 32'(lights4), 32'h921);
        check4("rst_now", PH_G, 0, 0);
        rst4 = 1'b0;
        cyc = 0;
        step(6);
        check4("rst_c6", PH_G, 0, 0);
        step(1);
        check4("rst_c7", PH_Y, 0, 0);
        step(3);
        check("rst_c10_lights", 32'(lights4), 32'h90C);
        check4("rst_c10", PH_G, 1, 0);

        // 6. Out-of-range preemption on the 5-approach build is ignored
        reset5();
        demand5 = 5'b11111;
        preq5   = 1'b1;
        pdir5   = 3'd7;
        tbl.delete();
        tbl.push_back(mk(0,  PH_G, 0, 0));
        tbl.push_back(mk(6,  PH_G, 0, 0));
        tbl.push_back(mk(7,  PH_Y, 0, 0));
        tbl.push_back(mk(9,  PH_A, 0, 0));
        tbl.push_back(mk(10, PH_G, 1, 0));
        tbl.push_back(mk(20, PH_G, 2, 0));
        tbl.push_back(mk(30, PH_G, 3, 0));
        tbl.push_back(mk(40, PH_G, 4, 0));
        tbl.push_back(mk(47, PH_Y, 4, 0));
        tbl.push_back(mk(49, PH_A, 4, 0));
        tbl.push_back(mk(50, PH_G, 0, 0));
        run_table("inv_pre", 1'b1, 50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
